// File: rtl/instr_encoder.sv
// Packs micro-op requests into 32-bit instruction words, queues them in a small FIFO and writes them to
// instruction memory over a req/ack port. Define ENC_FLUSH_EN to add the synchronous `flush` input.
module instr_encoder #(
    parameter int DATA_WIDTH = 31,
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_opc,
    input  logic [4:0]            req_rs,
    input  logic [4:0]            req_rt,
    input  logic [4:0]            req_rd,
    input  logic [15:0]           req_offset,
    input  logic                  load_start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
`ifdef ENC_FLUSH_EN
    input  logic                  flush,
`endif
    output logic                  imem_wr,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH:0]   imem_data,
    input  logic                  imem_ack,
    output logic                  busy,
    output logic                  err_illegal,
    output logic                  wrapped
);

    localparam int DW    = DATA_WIDTH + 1;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_WRITE = 1'b1;

`ifndef ENC_FLUSH_EN
    logic flush;
    assign flush = 1'b0;
`endif

    logic [DW-1:0]         mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_nxt;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [0:0]            state_q, state_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DW-1:0]         data_q, data_d;
    logic                  err_q, err_d, wrap_q, wrap_d;
    logic                  accept, push, pop;
    logic [5:0]            funct;
    logic [DW-1:0]         enc_word;

    assign req_ready   = (count_q != CNT_W'(DEPTH));
    assign busy        = (count_q != '0) || (state_q == S_WRITE);
    assign imem_wr     = wr_q;
    assign imem_addr   = addr_q;
    assign imem_data   = data_q;
    assign err_illegal = err_q;
    assign wrapped     = wrap_q;
    assign rd_nxt      = rd_ptr_q + PTR_W'(1);

    always_comb begin
        funct = 6'd0;
        case (req_opc)
            3'd0:    funct = 6'd32;
            3'd1:    funct = 6'd34;
            3'd2:    funct = 6'd36;
            3'd3:    funct = 6'd37;
            3'd4:    funct = 6'd50;
            default: funct = 6'd0;
        endcase
        case (req_opc)
            3'd5:    enc_word = DW'({6'b000011, req_rs, req_rt, req_offset});
            3'd6:    enc_word = DW'({6'b000100, req_rs, req_rt, req_offset});
            default: enc_word = DW'({6'b000010, req_rs, req_rt, req_rd, 5'b01010, funct});
        endcase
    end

    always_comb begin
        state_d  = state_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        data_d   = data_q;
        err_d    = err_q;
        wrap_d   = wrap_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pop      = 1'b0;
        accept   = req_valid && req_ready && !flush;
        push     = accept && (req_opc != 3'd7);

        if (accept && (req_opc == 3'd7))
            err_d = 1'b1;

        if (flush) begin
            state_d  = S_IDLE;
            wr_d     = 1'b0;
            addr_d   = start_addr;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (count_q != '0) begin
                        data_d  = mem_q[rd_ptr_q];
                        wr_d    = 1'b1;
                        state_d = S_WRITE;
                    end
                end
                default: begin
                    if (imem_ack) begin
                        pop    = 1'b1;
                        addr_d = addr_q + ADDR_WIDTH'(1);
                        if (&addr_q)
                            wrap_d = 1'b1;
                        // Head stays queued until acked, so the follower sits one slot behind it.
                        if (count_q > CNT_W'(1)) begin
                            data_d = mem_q[rd_nxt];
                        end else if (push) begin
                            data_d = enc_word;
                        end else begin
                            wr_d    = 1'b0;
                            state_d = S_IDLE;
                        end
                    end
                end
            endcase

            if (load_start && !busy)
                addr_d = start_addr;

            if (push)
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)
                rd_ptr_d = rd_nxt;
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= enc_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
            wrap_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            err_q    <= err_d;
            wrap_q   <= wrap_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: encoding table, directed multi-cycle sequences, then random traffic vs. a queue model.
module tb_instr_encoder;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [2:0]  req_opc;
    logic [4:0]  req_rs, req_rt, req_rd;
    logic [15:0] req_offset;
    logic        load_start;
    logic [7:0]  start_addr;
    logic        imem_wr;
    logic [7:0]  imem_addr;
    logic [31:0] imem_data;
    logic        imem_ack;
    logic        busy, err_illegal, wrapped;

    instr_encoder #(.DATA_WIDTH(31), .DEPTH(DEPTH), .ADDR_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_opc(req_opc),
        .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_offset(req_offset),
        .load_start(load_start), .start_addr(start_addr),
        .imem_wr(imem_wr), .imem_addr(imem_addr), .imem_data(imem_data), .imem_ack(imem_ack),
        .busy(busy), .err_illegal(err_illegal), .wrapped(wrapped)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;
    wr_t wq[$];

    typedef struct {
        logic [2:0]  opc;
        logic [4:0]  rs, rt, rd;
        logic [15:0] off;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[10];

    always @(posedge clk) cyc <= cyc + 1;

    // Every completed memory write, as seen on the bus.
    always @(negedge clk)
        if (rst === 1'b0 && imem_wr && imem_ack)
            wq.push_back('{imem_addr, imem_data, cyc});

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Instruction word from the format rules, built by field weights.
    function automatic logic [31:0] enc(input int unsigned opc, input int unsigned rs,
                                        input int unsigned rt, input int unsigned rd,
                                        input int unsigned off);
        int unsigned f;
        case (opc)
            0: f = 32;
            1: f = 34;
            2: f = 36;
            3: f = 37;
            default: f = 50;
        endcase
        if (opc == 5) return 32'(3 * (1 << 26) + rs * (1 << 21) + rt * (1 << 16) + off);
        if (opc == 6) return 32'(4 * (1 << 26) + rs * (1 << 21) + rt * (1 << 16) + off);
        return 32'(2 * (1 << 26) + rs * (1 << 21) + rt * (1 << 16) + rd * (1 << 11) + 10 * 64 + f);
    endfunction

    task automatic send(input logic [2:0] opc, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [15:0] off);
        bit ok = 1'b0;
        req_valid = 1'b1; req_opc = opc; req_rs = rs; req_rt = rt; req_rd = rd; req_offset = off;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1'b1; break; end
        end
        chk("send_accept", 32'(ok), 32'd1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("drain_idle", 32'(busy), 32'd0);
        tick();
    endtask

    task automatic wait_wr();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (imem_wr) break;
        end
        chk("wait_wr", 32'(imem_wr), 32'd1);
    endtask

    task automatic load(input logic [7:0] a);
        load_start = 1'b1; start_addr = a;
        tick();
        load_start = 1'b0;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    logic [31:0] mq[$];
    logic [7:0]  exp_addr;
    bit          exp_err, took;
    int          idle_run;

    initial begin
        tbl[0] = '{3'd0, 5'd1,  5'd2,  5'd3,  16'h0000, 32'h0822_1AA0};
        tbl[1] = '{3'd0, 5'd1,  5'd2,  5'd3,  16'hFFFF, 32'h0822_1AA0};
        tbl[2] = '{3'd1, 5'd0,  5'd0,  5'd0,  16'h0000, 32'h0800_02A2};
        tbl[3] = '{3'd2, 5'd31, 5'd31, 5'd31, 16'h0000, 32'h0BFF_FAA4};
        tbl[4] = '{3'd3, 5'd1,  5'd0,  5'd0,  16'h0000, 32'h0820_02A5};
        tbl[5] = '{3'd4, 5'd2,  5'd3,  5'd4,  16'h0000, 32'h0843_22B2};
        tbl[6] = '{3'd5, 5'd4,  5'd5,  5'd0,  16'h0008, 32'h0C85_0008};
        tbl[7] = '{3'd5, 5'd0,  5'd31, 5'd31, 16'hFFFF, 32'h0C1F_FFFF};
        tbl[8] = '{3'd6, 5'd4,  5'd6,  5'd0,  16'hFFFC, 32'h1086_FFFC};
        tbl[9] = '{3'd6, 5'd31, 5'd0,  5'd0,  16'h1234, 32'h13E0_1234};

        rst = 1'b1; req_valid = 1'b0; req_opc = '0; req_rs = '0; req_rt = '0; req_rd = '0;
        req_offset = '0; load_start = 1'b0; start_addr = '0; imem_ack = 1'b0;
        tick(); tick();
        chk("rst_imem_wr",   32'(imem_wr), 32'd0);
        chk("rst_imem_addr", 32'(imem_addr), 32'd0);
        chk("rst_imem_data", imem_data, 32'd0);
        chk("rst_busy",      32'(busy), 32'd0);
        chk("rst_err",       32'(err_illegal), 32'd0);
        chk("rst_wrapped",   32'(wrapped), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        tick();

        // Directed: first write lands at the loaded start address.
        load(8'h10);
        send(3'd0, 5'd1, 5'd2, 5'd3, 16'h0);
        wait_wr();
        chk("t1_addr", 32'(imem_addr), 32'h10);
        chk("t1_data", imem_data, 32'h0822_1AA0);
        tick(); imem_ack = 1'b1;
        tick(); imem_ack = 1'b0;
        @(negedge clk);
        chk("t1_next_addr", 32'(imem_addr), 32'h11);
        chk("t1_wr_low", 32'(imem_wr), 32'd0);
        tick();

        imem_ack = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wq.delete();
            send(tbl[i].opc, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].off);
            drain();
            chk($sformatf("tbl%0d_count", i), 32'(wq.size()), 32'd1);
            if (wq.size() > 0) chk($sformatf("tbl%0d_word", i), wq[0].data, tbl[i].exp);
        end

        // Back-to-back LW/SW with ack held high.
        wq.delete();
        send(3'd5, 5'd4, 5'd5, 5'd0, 16'h0008);
        send(3'd6, 5'd4, 5'd6, 5'd0, 16'hFFFC);
        drain();
        chk("b2b_count", 32'(wq.size()), 32'd2);
        if (wq.size() == 2) begin
            chk("b2b_w0", wq[0].data, 32'h0C85_0008);
            chk("b2b_w1", wq[1].data, 32'h1086_FFFC);
            chk("b2b_gap", 32'(wq[1].cyc - wq[0].cyc), 32'd1);
        end

        // FIFO full with ack low; fifth request waits for the first pop.
        imem_ack = 1'b0;
        wq.delete();
        for (int i = 0; i < 4; i++) send(3'd0, 5'd1, 5'd1, 5'(i), 16'h0);
        req_valid = 1'b1; req_opc = 3'd0; req_rs = 5'd1; req_rt = 5'd1; req_rd = 5'd4;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("full_ready_low", 32'(req_ready), 32'd0);
            tick();
        end
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        @(negedge clk);
        chk("ready_after_pop", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        imem_ack = 1'b1;
        drain();
        chk("full_count", 32'(wq.size()), 32'd5);
        for (int i = 0; i < wq.size(); i++)
            chk($sformatf("full_order%0d", i), wq[i].data, enc(0, 1, 1, i, 0));

        // Illegal opcode between two MULs.
        chk("err_before", 32'(err_illegal), 32'd0);
        wq.delete();
        send(3'd4, 5'd1, 5'd2, 5'd3, 16'h0);
        send(3'd7, 5'd9, 5'd9, 5'd9, 16'h0);
        send(3'd4, 5'd5, 5'd6, 5'd7, 16'h0);
        drain();
        chk("illegal_err", 32'(err_illegal), 32'd1);
        chk("illegal_count", 32'(wq.size()), 32'd2);
        for (int i = 0; i < wq.size(); i++)
            chk($sformatf("illegal_funct%0d", i), 32'(wq[i].data[5:0]), 32'd50);

        // Address wrap.
        chk("wrap_before", 32'(wrapped), 32'd0);
        load(8'hFF);
        wq.delete();
        send(3'd1, 5'd1, 5'd1, 5'd1, 16'h0);
        send(3'd2, 5'd2, 5'd2, 5'd2, 16'h0);
        drain();
        chk("wrap_count", 32'(wq.size()), 32'd2);
        if (wq.size() == 2) begin
            chk("wrap_a0", 32'(wq[0].addr), 32'hFF);
            chk("wrap_a1", 32'(wq[1].addr), 32'h00);
        end
        chk("wrap_flag", 32'(wrapped), 32'd1);

        // Reset in the middle of a pending write.
        imem_ack = 1'b0;
        send(3'd3, 5'd3, 5'd3, 5'd3, 16'h0);
        wait_wr();
        #1 rst = 1'b1;
        #1;
        chk("midrst_wr", 32'(imem_wr), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        tick();
        rst = 1'b0;
        imem_ack = 1'b1;
        wq.delete();
        send(3'd0, 5'd7, 5'd7, 5'd7, 16'h0);
        drain();
        chk("midrst_count", 32'(wq.size()), 32'd1);
        if (wq.size() > 0) chk("midrst_addr", 32'(wq[0].addr), 32'd0);

        // Random traffic against the queue model.
        reset_pulse();
        mq.delete();
        exp_addr = 8'h00; exp_err = 1'b0; took = 1'b0; idle_run = 0;
        for (int c = 0; c < 700; c++) begin
            if (c >= 650) begin
                req_valid = 1'b0;
                imem_ack  = 1'b1;
            end else begin
                if (!req_valid || took) begin
                    req_valid  = 1'($urandom_range(0, 1));
                    req_opc    = 3'($urandom_range(0, 7));
                    req_rs     = 5'($urandom);
                    req_rt     = 5'($urandom);
                    req_rd     = 5'($urandom);
                    req_offset = 16'($urandom);
                end
                imem_ack = ($urandom_range(0, 3) != 0);
            end
            @(negedge clk);
            chk("rnd_ready", 32'(req_ready), 32'(mq.size() < DEPTH));
            chk("rnd_busy", 32'(busy), 32'(mq.size() != 0));
            chk("rnd_err", 32'(err_illegal), 32'(exp_err));
            if (mq.size() != 0 && !imem_wr) begin
                idle_run++;
                chk("rnd_wr_latency", 32'(idle_run <= 1), 32'd1);
            end else begin
                idle_run = 0;
            end
            took = req_valid && (mq.size() < DEPTH);
            if (imem_wr) begin
                if (mq.size() == 0) begin
                    chk("rnd_spurious_wr", 32'(imem_wr), 32'd0);
                end else begin
                    chk("rnd_data", imem_data, mq[0]);
                    chk("rnd_addr", 32'(imem_addr), 32'(exp_addr));
                    if (imem_ack) begin
                        void'(mq.pop_front());
                        exp_addr = exp_addr + 8'd1;
                    end
                end
            end
            if (took) begin
                if (req_opc == 3'd7) exp_err = 1'b1;
                else mq.push_back(enc(req_opc, req_rs, req_rt, req_rd, req_offset));
            end
            tick();
        end
        chk("rnd_drained", 32'(mq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
